mem_stage_module: RTL and testbench

Memory stage of the 5-stage ARM pipeline. Consumes the EXE/MEM outputs (write-back enable, memory read/write enables, ALU result, store data, destination register) and performs loads and stores against an internal word-addressed data memory with a fixed multi-cycle latency. While an access is in flight it stalls the upstream pipeline through `freeze`, then loads the MEM/WB pipeline register that feeds the write-back stage.

---
 rtl/mem_stage_module.sv | 149 ++++++++++++++
 tb/tb_mem_stage_module.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_module.sv
// Memory stage of the 5-stage ARM pipeline.
// Performs loads and stores against an internal word-addressed data memory
// with a fixed multi-cycle latency, stalls upstream through `freeze` while an
// access is in flight, and loads the MEM/WB pipeline register.
// Optional feature macro: MEM_ADDR_CHECK_EN (address range/alignment checking).
module mem_stage_module #(
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] val_r_m_in,
    input  logic [3:0]  dest_in,
    output logic        freeze,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] mem_data_out,
    output logic [3:0]  dest_out,
    output logic        addr_err_out
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] BASE     = 32'(BASE_ADDR);
    localparam logic [31:0] LIMIT    = 32'(BASE_ADDR + 4 * DEPTH);
    // Only meaningful when WAIT_CYCLES >= 2; the single-cycle case skips ACCESS.
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    // Data memory; contents are intentionally not reset.
    logic [31:0] mem_array [DEPTH];

    logic          req;
    logic [AW-1:0] word_idx;
    logic          addr_bad;
    logic          access_err;
    logic          mem_we;
    logic [31:0]   load_data;

    assign req      = mem_r_en_in | mem_w_en_in;
    // Index wraps modulo DEPTH and ignores the byte-lane bits.
    assign word_idx = AW'((alu_res_in - BASE) >> 2);

`ifdef MEM_ADDR_CHECK_EN
    assign addr_bad = (alu_res_in < BASE) || (alu_res_in >= LIMIT) ||
                      (alu_res_in[1:0] != 2'b00);
`else
    assign addr_bad = 1'b0;
`endif

    assign access_err = req & addr_bad;

    // A store commits only on the edge that leaves DONE, so a reset before
    // that edge discards it.
    assign mem_we = (state_reg == DONE) & mem_w_en_in & ~addr_bad;

    // Combinational read; a combined load+store or a bad address returns 0.
    assign load_data = (mem_w_en_in | addr_bad) ? 32'd0 : mem_array[word_idx];

    // State register for the access sequencer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic and stall generation.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        freeze     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    freeze = 1'b1;
                    if (WAIT_CYCLES == 1) begin
                        state_next = DONE;
                    end else begin
                        state_next = ACCESS;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            ACCESS: begin
                freeze = 1'b1;
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[word_idx] <= val_r_m_in;
        end
    end

    // MEM/WB pipeline register: bubble while stalled, otherwise load fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            alu_res_out  <= 32'd0;
            mem_data_out <= 32'd0;
            dest_out     <= 4'd0;
            addr_err_out <= 1'b0;
        end else if (freeze) begin
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
        end else begin
            wb_en_out    <= wb_en_in;
            mem_r_en_out <= mem_r_en_in;
            alu_res_out  <= alu_res_in;
            dest_out     <= dest_in;
            addr_err_out <= access_err;
            if (mem_r_en_in) begin
                mem_data_out <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_module.sv
// Self-checking bench for mem_stage_module (WAIT_CYCLES=2 main instance plus a
// WAIT_CYCLES=1 instance sharing the same inputs).
module tb_mem_stage_module;

    localparam int DEPTH = 64;
    localparam int WAIT  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [31:0] alu_res_in, val_r_m_in;
    logic [3:0]  dest_in;

    logic        freeze, wb_en_out, mem_r_en_out, addr_err_out;
    logic [31:0] alu_res_out, mem_data_out;
    logic [3:0]  dest_out;

    logic        freeze1, wb_en_out1, mem_r_en_out1, addr_err_out1;
    logic [31:0] alu_res_out1, mem_data_out1;
    logic [3:0]  dest_out1;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_alu = 32'd0;

    always #5 clk = ~clk;

    mem_stage_module #(.DEPTH(DEPTH), .BASE_ADDR(1024), .WAIT_CYCLES(WAIT)) u_dut (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_res_in(alu_res_in), .val_r_m_in(val_r_m_in), .dest_in(dest_in),
        .freeze(freeze), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .alu_res_out(alu_res_out), .mem_data_out(mem_data_out),
        .dest_out(dest_out), .addr_err_out(addr_err_out)
    );

    mem_stage_module #(.DEPTH(DEPTH), .BASE_ADDR(1024), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_res_in(alu_res_in), .val_r_m_in(val_r_m_in), .dest_in(dest_in),
        .freeze(freeze1), .wb_en_out(wb_en_out1), .mem_r_en_out(mem_r_en_out1),
        .alu_res_out(alu_res_out1), .mem_data_out(mem_data_out1),
        .dest_out(dest_out1), .addr_err_out(addr_err_out1)
    );

    typedef struct {
        logic        wb;
        logic        r;
        logic        w;
        logic [31:0] alu;
        logic [31:0] val;
        logic [3:0]  dest;
        logic        e_wb;
        logic        e_mr;
        logic [31:0] e_alu;
        logic [31:0] e_data;
        logic [3:0]  e_dest;
        logic        e_err;
    } op_t;

    op_t sb_q[$];
    op_t vec[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_val);
        checks++;
        if (act !== exp_val) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_val);
        end
    endtask

    task automatic drive_idle();
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        alu_res_in = 32'd0; val_r_m_in = 32'd0; dest_in = 4'd0;
    endtask

    function automatic op_t mk(input logic wb, input logic r, input logic w,
                               input logic [31:0] alu, input logic [31:0] val,
                               input logic [3:0] dest, input logic [31:0] e_data,
                               input logic e_err);
        op_t o;
        o.wb = wb; o.r = r; o.w = w; o.alu = alu; o.val = val; o.dest = dest;
        o.e_wb = wb; o.e_mr = r; o.e_alu = alu; o.e_data = e_data;
        o.e_dest = dest; o.e_err = e_err;
        return o;
    endfunction

    // Present one instruction to the main instance, honour freeze, compare.
    task automatic run_op(input op_t v);
        op_t exp_v;
        int  fz;
        int  exp_fz;
        bit  done;
        @(negedge clk);
        wb_en_in = v.wb; mem_r_en_in = v.r; mem_w_en_in = v.w;
        alu_res_in = v.alu; val_r_m_in = v.val; dest_in = v.dest;
        sb_q.push_back(v);
        exp_fz = (v.r | v.w) ? WAIT : 0;
        fz = 0;
        done = 1'b0;
        for (int k = 0; k < 32 && !done; k++) begin
            #1;
            if (!freeze) begin
                done = 1'b1;
            end else begin
                fz++;
                @(posedge clk);
                #1;
                chk("bubble_wb_en", {31'd0, wb_en_out}, 32'd0);
                chk("bubble_mem_r_en", {31'd0, mem_r_en_out}, 32'd0);
                chk("bubble_alu_hold", alu_res_out, last_alu);
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL freeze_timeout: freeze still high after 32 cycles");
        end
        chk("freeze_cycles", 32'(fz), 32'(exp_fz));
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        chk("wb_en_out", {31'd0, wb_en_out}, {31'd0, exp_v.e_wb});
        chk("mem_r_en_out", {31'd0, mem_r_en_out}, {31'd0, exp_v.e_mr});
        chk("alu_res_out", alu_res_out, exp_v.e_alu);
        chk("mem_data_out", mem_data_out, exp_v.e_data);
        chk("dest_out", {28'd0, dest_out}, {28'd0, exp_v.e_dest});
        chk("addr_err_out", {31'd0, addr_err_out}, {31'd0, exp_v.e_err});
        last_alu = exp_v.e_alu;
        $display("txn wb=%0b r=%0b w=%0b addr=0x%08h data_out=0x%08h err=%0b stall=%0d",
                 v.wb, v.r, v.w, v.alu, mem_data_out, addr_err_out, fz);
    endtask

    initial begin
        // Vector table: {wb, r, w, alu, val, dest} -> expected outputs.
        vec[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 4'd5,  32'h0000_0000, 1'b0);
        vec[1]  = mk(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'd15, 32'h0000_0000, 1'b0);
        vec[2]  = mk(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4'd0, 32'h0000_0000, 1'b0);
        vec[3]  = mk(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd3, 32'hDEAD_BEEF, 1'b0);
        vec[4]  = mk(1'b0, 1'b0, 1'b1, 32'd1036, 32'h0BAD_F00D, 4'd1, 32'hDEAD_BEEF, 1'b0);
        vec[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'd7, 32'hDEAD_BEEF, 1'b0);
        vec[6]  = mk(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd2, 32'h0BAD_F00D, 1'b0);
        vec[7]  = mk(1'b1, 1'b1, 1'b1, 32'd1040, 32'h1234_5678, 4'd9, 32'h0000_0000, 1'b0);
        vec[8]  = mk(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd4, 32'h1234_5678, 1'b0);
        vec[9]  = mk(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd6, 32'hDEAD_BEEF, 1'b0);
        vec[10] = mk(1'b0, 1'b0, 1'b1, 32'd1032, 32'h1111_1111, 4'd0, 32'hDEAD_BEEF, 1'b0);
        vec[11] = mk(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd8, 32'h1111_1111, 1'b0);

        // Reset with random non-memory inputs.
        rst = 1'b0;
        drive_idle();
        wb_en_in = 1'($urandom); alu_res_in = $urandom; val_r_m_in = $urandom;
        dest_in = 4'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_en", {31'd0, wb_en_out}, 32'd0);
        chk("rst_mem_r_en", {31'd0, mem_r_en_out}, 32'd0);
        chk("rst_alu_res", alu_res_out, 32'd0);
        chk("rst_mem_data", mem_data_out, 32'd0);
        chk("rst_dest", {28'd0, dest_out}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err_out}, 32'd0);
        chk("rst_freeze_noreq", {31'd0, freeze}, 32'd0);
        mem_r_en_in = 1'b1;
        #1;
        chk("rst_freeze_req", {31'd0, freeze}, 32'd1);
        drive_idle();
        @(negedge clk);
        rst = 1'b1;

        // Table-driven sequence.
        for (int i = 0; i < 12; i++) begin
            run_op(vec[i]);
        end

        // Reset in the middle of a store's ACCESS phase.
        @(negedge clk);
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
        alu_res_in = 32'd1032; val_r_m_in = 32'h0000_0055; dest_in = 4'd0;
        @(posedge clk);
        #1;
        chk("mid_freeze_access", {31'd0, freeze}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_wb_en", {31'd0, wb_en_out}, 32'd0);
        chk("mid_rst_alu_res", alu_res_out, 32'd0);
        chk("mid_rst_mem_data", mem_data_out, 32'd0);
        chk("mid_rst_dest", {28'd0, dest_out}, 32'd0);
        chk("mid_rst_freeze_req", {31'd0, freeze}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        #1;
        chk("mid_rst_freeze_idle", {31'd0, freeze}, 32'd0);
        rst = 1'b1;
        last_alu = 32'd0;
        run_op(mk(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd8, 32'h1111_1111, 1'b0));

`ifdef MEM_ADDR_CHECK_EN
        run_op(mk(1'b0, 1'b0, 1'b1, 32'd1276, 32'h2222_2222, 4'd0, 32'h1111_1111, 1'b0));
        run_op(mk(1'b0, 1'b0, 1'b1, 32'd1022, 32'hAAAA_AAAA, 4'd0, 32'h1111_1111, 1'b1));
        run_op(mk(1'b1, 1'b1, 1'b0, 32'd1276, 32'h0, 4'd1, 32'h2222_2222, 1'b0));
        run_op(mk(1'b1, 1'b1, 1'b0, 32'd1024 + 4 * DEPTH, 32'h0, 4'd2, 32'h0000_0000, 1'b1));
        run_op(mk(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd3, 32'hDEAD_BEEF, 1'b0));
        run_op(mk(1'b1, 1'b1, 1'b0, 32'd1030, 32'h0, 4'd4, 32'h0000_0000, 1'b1));
        run_op(mk(1'b1, 1'b0, 1'b0, 32'h0000_0099, 32'h0, 4'd5, 32'h0000_0000, 1'b0));
`else
        run_op(mk(1'b0, 1'b0, 1'b1, 32'd1024 + 4 * DEPTH, 32'h0000_0077, 4'd0, 32'h1111_1111, 1'b0));
        run_op(mk(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd1, 32'h0000_0077, 1'b0));
        run_op(mk(1'b1, 1'b1, 1'b0, 32'd1030, 32'h0, 4'd2, 32'hDEAD_BEEF, 1'b0));
`endif

        // WAIT_CYCLES=1 instance: reset both, then store and load.
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_w_en_in = 1'b1; alu_res_in = 32'd1044; val_r_m_in = 32'hCAFE_F00D;
        #1;
        chk("w1_store_freeze", {31'd0, freeze1}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("w1_store_done_freeze", {31'd0, freeze1}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        wb_en_in = 1'b1; mem_r_en_in = 1'b1; alu_res_in = 32'd1044; dest_in = 4'd10;
        #1;
        chk("w1_load_freeze", {31'd0, freeze1}, 32'd1);
        @(posedge clk);
        #1;
        chk("w1_bubble_wb_en", {31'd0, wb_en_out1}, 32'd0);
        chk("w1_bubble_mem_r_en", {31'd0, mem_r_en_out1}, 32'd0);
        @(negedge clk);
        #1;
        chk("w1_load_done_freeze", {31'd0, freeze1}, 32'd0);
        @(posedge clk);
        #1;
        chk("w1_mem_data_out", mem_data_out1, 32'hCAFE_F00D);
        chk("w1_mem_r_en_out", {31'd0, mem_r_en_out1}, 32'd1);
        chk("w1_wb_en_out", {31'd0, wb_en_out1}, 32'd1);
        chk("w1_dest_out", {28'd0, dest_out1}, 32'd10);
        $display("txn w1 load addr=0x%08h data_out=0x%08h", 32'd1044, mem_data_out1);
        @(negedge clk);
        drive_idle();
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

endmodule
